// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, mode-register bit positions
// and the init sequencer state type.
package sdram_pkg;

    localparam int unsigned CMD_W = 4;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_LMR  = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_DESL = 4'b1111;

    localparam int unsigned MR_BL_LSB   = 0;
    localparam int unsigned MR_BT_BIT   = 3;
    localparam int unsigned MR_CL_LSB   = 4;
    localparam int unsigned MR_WBM_BIT  = 9;
    localparam int unsigned MR_W        = 10;
    localparam int unsigned PRE_ALL_BIT = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRE,
        S_AREF,
        S_LMR,
        S_EMR,
        S_NEXT_RANK,
        S_DONE
    } init_seq_state_t;

    // Low mode-register field; reserved bits [8:7] stay zero.
    function automatic logic [MR_W-1:0] mode_bits(
        input logic [2:0] burst_length,
        input logic       burst_type,
        input logic [2:0] cas_latency,
        input logic       burst_mode
    );
        logic [MR_W-1:0] m;
        m = '0;
        m[MR_BL_LSB +: 3] = burst_length;
        m[MR_BT_BIT]      = burst_type;
        m[MR_CL_LSB +: 3] = cas_latency;
        m[MR_WBM_BIT]     = burst_mode;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Loadable down-counter that stops at zero; expired_c flags a zero count.
module sdram_init_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up / re-init command sequencer with valid/ready handshake.
// Define SDRAM_EMRS_EN to add the extended mode register (EMR) step per rank.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50,
    parameter int unsigned AW       = 12,
    parameter int unsigned BAW      = 2,
    parameter int unsigned NUM_RANK = 1,
    parameter int unsigned INIT_US  = 100,
    parameter int unsigned NUM_AREF = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          cfg_burst_length,
    input  logic                cfg_burst_type,
    input  logic [2:0]          cfg_cas_latency,
    input  logic                cfg_burst_mode,
`ifdef SDRAM_EMRS_EN
    input  logic [AW-1:0]       cfg_ext_mode,
`endif
    input  logic                init_start,
    output logic                init_valid,
    output logic [CMD_W-1:0]    init_cmd,
    output logic [AW-1:0]       init_addr,
    output logic [BAW-1:0]      init_ba,
    output logic [NUM_RANK-1:0] init_cs,
    input  logic                cmd_ready,
    input  logic                cmd_done,
    output logic                init_busy,
    output logic                init_done
);

    localparam int unsigned WAIT_CYC = INIT_US * CLK_FREQ;
    localparam int unsigned TW       = $clog2(WAIT_CYC + 1);
    localparam int unsigned ACW      = $clog2(NUM_AREF + 1);
    localparam int unsigned RW       = (NUM_RANK > 1) ? $clog2(NUM_RANK) : 1;

    init_seq_state_t     state, state_nx;
    logic                valid_nx, busy_nx, done_nx;
    logic [CMD_W-1:0]    cmd_nx;
    logic [AW-1:0]       addr_nx;
    logic [BAW-1:0]      ba_nx;
    logic [NUM_RANK-1:0] cs_nx;
    logic                accepted, accepted_nx;
    logic [ACW-1:0]      aref_cnt, aref_nx;
    logic [RW-1:0]       rank, rank_nx;
    logic                issue, accept, fin;
    logic                tmr_expired;

    sdram_init_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (state == S_IDLE),
        .load_val  (TW'(WAIT_CYC - 1)),
        .en        (state == S_WAIT),
        .expired_c (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            init_valid <= 1'b0;
            init_cmd   <= CMD_DESL;
            init_addr  <= '0;
            init_ba    <= '0;
            init_cs    <= '0;
            init_busy  <= 1'b0;
            init_done  <= 1'b0;
            accepted   <= 1'b0;
            aref_cnt   <= '0;
            rank       <= '0;
        end else begin
            state      <= state_nx;
            init_valid <= valid_nx;
            init_cmd   <= cmd_nx;
            init_addr  <= addr_nx;
            init_ba    <= ba_nx;
            init_cs    <= cs_nx;
            init_busy  <= busy_nx;
            init_done  <= done_nx;
            accepted   <= accepted_nx;
            aref_cnt   <= aref_nx;
            rank       <= rank_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        valid_nx    = init_valid;
        cmd_nx      = init_cmd;
        addr_nx     = init_addr;
        ba_nx       = init_ba;
        cs_nx       = init_cs;
        busy_nx     = init_busy;
        done_nx     = init_done;
        accepted_nx = accepted;
        aref_nx     = aref_cnt;
        rank_nx     = rank;
        issue       = 1'b0;

        accept = init_valid & cmd_ready;
        // A done pulse only completes a command already accepted (or accepted now).
        fin    = (accept | accepted) & cmd_done;

        if (accept) begin
            valid_nx    = 1'b0;
            accepted_nx = 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                busy_nx  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (tmr_expired) begin
                    state_nx = S_PRE;
                    issue    = 1'b1;
                end
            end
            S_PRE: begin
                if (fin) begin
                    state_nx = S_AREF;
                    aref_nx  = '0;
                    issue    = 1'b1;
                end
            end
            S_AREF: begin
                if (fin) begin
                    issue = 1'b1;
                    if (aref_cnt == ACW'(NUM_AREF - 1)) begin
                        aref_nx  = '0;
                        state_nx = S_LMR;
                    end else begin
                        aref_nx = aref_cnt + ACW'(1);
                    end
                end
            end
            S_LMR: begin
                if (fin) begin
`ifdef SDRAM_EMRS_EN
                    state_nx = S_EMR;
                    issue    = 1'b1;
`else
                    state_nx = S_NEXT_RANK;
`endif
                end
            end
`ifdef SDRAM_EMRS_EN
            S_EMR: begin
                if (fin) state_nx = S_NEXT_RANK;
            end
`endif
            S_NEXT_RANK: begin
                if (rank == RW'(NUM_RANK - 1)) begin
                    state_nx = S_DONE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    rank_nx  = rank + RW'(1);
                    state_nx = S_PRE;
                    issue    = 1'b1;
                end
            end
            S_DONE: begin
                if (init_start) begin
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    rank_nx  = '0;
                    state_nx = S_PRE;
                    issue    = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (state_nx == S_NEXT_RANK) begin
            valid_nx = 1'b0;
            cmd_nx   = CMD_DESL;
            cs_nx    = '0;
        end

        // Launch the command of the state being entered; fields then hold until accept.
        if (issue) begin
            valid_nx    = 1'b1;
            accepted_nx = 1'b0;
            addr_nx     = '0;
            ba_nx       = '0;
            cs_nx       = NUM_RANK'(1) << rank_nx;
            unique case (state_nx)
                S_PRE: begin
                    cmd_nx               = CMD_PRE;
                    addr_nx[PRE_ALL_BIT] = 1'b1;
                end
                S_AREF: cmd_nx = CMD_AREF;
                S_LMR: begin
                    cmd_nx  = CMD_LMR;
                    addr_nx = AW'(mode_bits(cfg_burst_length, cfg_burst_type,
                                            cfg_cas_latency, cfg_burst_mode));
                end
`ifdef SDRAM_EMRS_EN
                S_EMR: begin
                    cmd_nx  = CMD_LMR;
                    ba_nx   = BAW'(2'b10);
                    addr_nx = cfg_ext_mode;
                end
`endif
                default: cmd_nx = CMD_DESL;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench for sdram_init_seq: two ranks, three refreshes, 10-cycle power-up wait.
module tb_sdram_init_seq;
    import sdram_pkg::*;

    localparam int unsigned AW       = 12;
    localparam int unsigned BAW      = 2;
    localparam int unsigned NUM_RANK = 2;
    localparam int unsigned NUM_AREF = 3;
    localparam int          WAIT_EXP = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [2:0]          cfg_burst_length = 3'b011;
    logic                cfg_burst_type   = 1'b0;
    logic [2:0]          cfg_cas_latency  = 3'b010;
    logic                cfg_burst_mode   = 1'b1;
`ifdef SDRAM_EMRS_EN
    logic [AW-1:0]       cfg_ext_mode     = 12'h5A5;
`endif
    logic                init_start = 1'b0;
    logic                cmd_ready  = 1'b1;
    logic                cmd_done   = 1'b0;
    logic                init_valid;
    logic [CMD_W-1:0]    init_cmd;
    logic [AW-1:0]       init_addr;
    logic [BAW-1:0]      init_ba;
    logic [NUM_RANK-1:0] init_cs;
    logic                init_busy;
    logic                init_done;

    typedef struct {
        logic [CMD_W-1:0]    cmd;
        logic [AW-1:0]       addr;
        logic [BAW-1:0]      ba;
        logic [NUM_RANK-1:0] cs;
        logic                chk_addr;
        int                  hold;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int stall = 0;

    sdram_init_seq #(
        .CLK_FREQ(1), .AW(AW), .BAW(BAW), .NUM_RANK(NUM_RANK), .INIT_US(10), .NUM_AREF(NUM_AREF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_burst_length (cfg_burst_length),
        .cfg_burst_type   (cfg_burst_type),
        .cfg_cas_latency  (cfg_cas_latency),
        .cfg_burst_mode   (cfg_burst_mode),
`ifdef SDRAM_EMRS_EN
        .cfg_ext_mode     (cfg_ext_mode),
`endif
        .init_start       (init_start),
        .init_valid       (init_valid),
        .init_cmd         (init_cmd),
        .init_addr        (init_addr),
        .init_ba          (init_ba),
        .init_cs          (init_cs),
        .cmd_ready        (cmd_ready),
        .cmd_done         (cmd_done),
        .init_busy        (init_busy),
        .init_done        (init_done)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected command stream for one full init pass.
    task automatic push_run(input logic [AW-1:0] lmr_addr, input int first_hold);
        exp_t e;
        for (int r = 0; r < NUM_RANK; r++) begin
            e.cs = (r == 0) ? 2'b01 : 2'b10;
            e.ba = 2'b00;
            e.cmd = CMD_PRE;  e.addr = 12'h400; e.chk_addr = 1'b1;
            e.hold = (r == 0) ? first_hold : 1;
            q.push_back(e);
            for (int a = 0; a < NUM_AREF; a++) begin
                e.cmd = CMD_AREF; e.addr = '0; e.chk_addr = 1'b0; e.hold = 1;
                q.push_back(e);
            end
            e.cmd = CMD_LMR; e.addr = lmr_addr; e.chk_addr = 1'b1; e.hold = 1;
            q.push_back(e);
`ifdef SDRAM_EMRS_EN
            e.cmd = CMD_LMR; e.addr = 12'h5A5; e.ba = 2'b10; e.chk_addr = 1'b1; e.hold = 1;
            q.push_back(e);
`endif
        end
    endtask

    // Arbiter model: optional stall, done two cycles after accept, stray done during stall.
    initial begin : responder
        int since;
        logic inject;
        since = 99;
        forever begin
            @(negedge clk);
            inject = 1'b0;
            if (rst) begin
                since     = 99;
                cmd_done  = 1'b0;
                cmd_ready = 1'b1;
            end else begin
                if (since < 99) since++;
                if (init_valid && stall > 0) begin
                    cmd_ready = 1'b0;
                    if (stall == 3) inject = 1'b1;
                    stall--;
                end else begin
                    cmd_ready = 1'b1;
                end
                cmd_done = (since == 2) || inject;
                if (init_valid && cmd_ready) since = 0;
            end
        end
    end

    // Compare every presented command against the scoreboard head; pop on accept.
    initial begin : monitor
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                run = 0;
            end else if (init_valid) begin
                run++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd: got cmd %0h addr %0h with empty scoreboard", init_cmd, init_addr);
                end else begin
                    check("cmd", 32'(init_cmd), 32'(q[0].cmd));
                    check("ba",  32'(init_ba),  32'(q[0].ba));
                    check("cs",  32'(init_cs),  32'(q[0].cs));
                    if (q[0].chk_addr) check("addr", 32'(init_addr), 32'(q[0].addr));
                    if (cmd_ready) begin
                        check("valid_hold", 32'(run), 32'(q[0].hold));
                        void'(q.pop_front());
                        run = 0;
                    end
                end
            end
        end
    end

    task automatic measure_wait();
        int n;
        int guard;
        n = 0;
        guard = 0;
        forever begin
            @(negedge clk);
            guard++;
            if (init_valid) break;
            if (init_busy) begin
                if (n == 0) check("wait_cmd_desl", 32'(init_cmd), 32'(CMD_DESL));
                n++;
            end
            if (guard > 100) begin
                total++; bad++;
                $display("FAIL wait_timeout: no command after %0d cycles", guard);
                break;
            end
        end
        check("wait_len", 32'(n), 32'(WAIT_EXP));
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while (!init_done && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!init_done) begin
            total++; bad++;
            $display("FAIL %s_done_timeout: init_done=%0b want 1", tag, init_done);
        end
        @(negedge clk);
        check({tag, "_done"},  32'(init_done),  32'd1);
        check({tag, "_busy"},  32'(init_busy),  32'd0);
        check({tag, "_valid"}, 32'(init_valid), 32'd0);
        check({tag, "_cs"},    32'(init_cs),    32'd0);
        check({tag, "_sb_empty"}, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_aref(input string tag);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(init_valid && init_cmd == CMD_AREF) && guard < 100);
        if (guard >= 100) begin
            total++; bad++;
            $display("FAIL %s_aref_timeout: no AREF seen", tag);
        end
    endtask

    task automatic pulse_start_expect_pre(input string tag);
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        check({tag, "_busy"},  32'(init_busy),  32'd1);
        check({tag, "_done"},  32'(init_done),  32'd0);
        check({tag, "_valid"}, 32'(init_valid), 32'd1);
        check({tag, "_cmd"},   32'(init_cmd),   32'(CMD_PRE));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(init_valid), 32'd0);
        check({tag, "_cmd"},   32'(init_cmd),   32'(CMD_DESL));
        check({tag, "_addr"},  32'(init_addr),  32'd0);
        check({tag, "_ba"},    32'(init_ba),    32'd0);
        check({tag, "_cs"},    32'(init_cs),    32'd0);
        check({tag, "_busy"},  32'(init_busy),  32'd0);
        check({tag, "_done"},  32'(init_done),  32'd0);
    endtask

    initial begin : stimulus
        // Pass 1: power-up with a 5-cycle stall on the first PRE.
        push_run(12'h223, 6);
        stall = 5;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;
        measure_wait();
        wait_done("pass1");

        // Pass 2: software re-init with new mode, init_start ignored mid-sequence.
        cfg_burst_length = 3'b010;
        cfg_burst_type   = 1'b1;
        cfg_cas_latency  = 3'b011;
        cfg_burst_mode   = 1'b0;
        push_run(12'h03A, 1);
        pulse_start_expect_pre("restart");
        wait_aref("pass2");
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        check("start_in_aref_busy", 32'(init_busy), 32'd1);
        check("start_in_aref_done", 32'(init_done), 32'd0);
        wait_done("pass2");

        // Pass 3: async reset mid-AREF, full sequence including WAIT repeats.
        push_run(12'h03A, 1);
        pulse_start_expect_pre("restart2");
        wait_aref("pass3");
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        q.delete();
        repeat (2) @(negedge clk);
        push_run(12'h03A, 1);
        rst = 1'b0;
        measure_wait();
        wait_done("pass3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
